// File: rtl/clock_scan.sv
// Digital clock core: 24-hour BCD time keeping with manual adjust, plus the
// 8-digit scan that feeds the 7-segment decoder.
module clock_scan #(
  parameter int SEC_DIV  = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       adj_min,
  input  logic       adj_hour,
  input  logic       clr_sec,
  output logic [3:0] din,
  output logic [7:0] sel,
  output logic       sec_tick,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);

  localparam int PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SEC_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0] DASH = 4'd10;

  logic [PW-1:0] presc, presc_n;
  logic [CW-1:0] scan_cnt, scan_cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    ss_n, mm_n, hh_n;
  logic [3:0]    din_n;
  logic          tick, sec_adv, min_carry, hour_carry;

  // 00..59 BCD increment; wraps 59 -> 00
  function automatic logic [7:0] inc_sexa(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // 00..23 BCD increment; wraps 23 -> 00
  function automatic logic [7:0] inc_hours(input logic [7:0] v);
    logic [7:0] r;
    if (v >= 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // clr_sec swallows a coincident tick, so it also suppresses the minute carry
  always_comb begin
    tick       = run && (presc == PMAX);
    sec_adv    = tick && !clr_sec;
    min_carry  = sec_adv && (ss == 8'h59);
    hour_carry = min_carry && (mm == 8'h59);

    presc_n = (!run || clr_sec || tick) ? '0 : presc + PW'(1);

    if (clr_sec)      ss_n = 8'h00;
    else if (sec_adv) ss_n = inc_sexa(ss);
    else              ss_n = ss;

    mm_n = (min_carry || adj_min)   ? inc_sexa(mm)  : mm;
    hh_n = (hour_carry || adj_hour) ? inc_hours(hh) : hh;
  end

  always_comb begin
    if (scan_cnt == CMAX) begin
      scan_cnt_n = '0;
      idx_n      = idx + 3'd1;
    end else begin
      scan_cnt_n = scan_cnt + CW'(1);
      idx_n      = idx;
    end
  end

  // din is built from next-state time so it always matches the registered hh/mm/ss
  always_comb begin
    din_n = DASH;
    case (idx_n)
      3'd0: din_n = ss_n[3:0];
      3'd1: din_n = ss_n[7:4];
      3'd3: din_n = mm_n[3:0];
      3'd4: din_n = mm_n[7:4];
      3'd6: din_n = hh_n[3:0];
      3'd7: din_n = hh_n[7:4];
      default: din_n = DASH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      scan_cnt <= '0;
      idx      <= 3'd0;
      ss       <= 8'h00;
      mm       <= 8'h00;
      hh       <= 8'h00;
      sec_tick <= 1'b0;
      din      <= 4'd0;
      sel      <= 8'hFE;
    end else begin
      presc    <= presc_n;
      scan_cnt <= scan_cnt_n;
      idx      <= idx_n;
      ss       <= ss_n;
      mm       <= mm_n;
      hh       <= hh_n;
      sec_tick <= sec_adv;
      din      <= din_n;
      sel      <= ~(8'b1 << idx_n);
    end
  end

endmodule
